// File: rtl/mips_multicycle_control_fsm_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// master: the control FSM (drives strobes, reads opcode/ready).
// slave : the datapath side (drives opcode/ready, reads strobes).
interface mips_multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       i_op_code;
  logic             i_mem_ready;
  logic [3:0]       o_state;
  logic             o_pc_write;
  logic             o_pc_write_cond;
  logic [1:0]       o_pc_src;
  logic             o_ir_write;
  logic             o_i_or_d;
  logic             o_mem_read;
  logic             o_mem_write;
  logic             o_mem_to_reg;
  logic             o_reg_dst;
  logic             o_w_en;
  logic             o_alu_src_a;
  logic [1:0]       o_alu_src_b;
  logic [1:0]       o_alu_op_code;
  logic             o_instr_retired;
  logic             o_illegal;
  logic [CNT_W-1:0] o_instr_count;

  modport master (
    input  i_op_code, i_mem_ready,
    output o_state, o_pc_write, o_pc_write_cond, o_pc_src, o_ir_write,
           o_i_or_d, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_dst,
           o_w_en, o_alu_src_a, o_alu_src_b, o_alu_op_code,
           o_instr_retired, o_illegal, o_instr_count
  );

  modport slave (
    output i_op_code, i_mem_ready,
    input  o_state, o_pc_write, o_pc_write_cond, o_pc_src, o_ir_write,
           o_i_or_d, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_dst,
           o_w_en, o_alu_src_a, o_alu_src_b, o_alu_op_code,
           o_instr_retired, o_illegal, o_instr_count
  );
endinterface

// File: rtl/mips_multicycle_control_fsm.sv
// Multicycle MIPS control FSM: sequences a shared-ALU, unified-memory
// datapath through fetch/decode/execute/memory/write-back states.
// Optional feature macro MIPS_FSM_INSTR_COUNT_EN adds a wrapping
// retired-instruction counter on o_instr_count; otherwise it is tied to 0.
module mips_multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic i_clk,
  input  logic i_reset,
  mips_multicycle_control_fsm_if.master bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  logic [3:0] state;
  logic [3:0] state_nxt;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_FETCH;
    else         state <= state_nxt;
  end

  // Next-state: memory states wait on ready, DECODE dispatches on opcode
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:     state_nxt = bus.i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.i_op_code)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (bus.i_op_code == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_nxt = bus.i_mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WR:    state_nxt = bus.i_mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_nxt = S_R_WB;
      S_R_WB:      state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_ADDI_WB:   state_nxt = S_FETCH;
      S_ILLEGAL:   state_nxt = S_ILLEGAL;
      default:     state_nxt = S_FETCH;
    endcase
  end

  assign bus.o_state = state;

  // Per-state datapath strobes; everything is held low while in reset
  always_comb begin
    bus.o_pc_write      = 1'b0;
    bus.o_pc_write_cond = 1'b0;
    bus.o_pc_src        = 2'b00;
    bus.o_ir_write      = 1'b0;
    bus.o_i_or_d        = 1'b0;
    bus.o_mem_read      = 1'b0;
    bus.o_mem_write     = 1'b0;
    bus.o_mem_to_reg    = 1'b0;
    bus.o_reg_dst       = 1'b0;
    bus.o_w_en          = 1'b0;
    bus.o_alu_src_a     = 1'b0;
    bus.o_alu_src_b     = 2'b00;
    bus.o_alu_op_code   = ALU_ADD;
    bus.o_instr_retired = 1'b0;
    bus.o_illegal       = 1'b0;
    if (!i_reset) begin
      case (state)
        S_FETCH: begin
          bus.o_mem_read  = 1'b1;
          bus.o_alu_src_b = 2'b01;
          bus.o_ir_write  = bus.i_mem_ready;
          bus.o_pc_write  = bus.i_mem_ready;
        end
        S_DECODE: begin
          bus.o_alu_src_b = 2'b11;
        end
        S_MEM_ADDR: begin
          bus.o_alu_src_a = 1'b1;
          bus.o_alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          bus.o_mem_read = 1'b1;
          bus.o_i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.o_mem_to_reg    = 1'b1;
          bus.o_w_en          = 1'b1;
          bus.o_instr_retired = 1'b1;
        end
        S_MEM_WR: begin
          bus.o_mem_write     = 1'b1;
          bus.o_i_or_d        = 1'b1;
          bus.o_instr_retired = bus.i_mem_ready;
        end
        S_R_EXEC: begin
          bus.o_alu_src_a   = 1'b1;
          bus.o_alu_op_code = ALU_FUNCT;
        end
        S_R_WB: begin
          bus.o_reg_dst       = 1'b1;
          bus.o_w_en          = 1'b1;
          bus.o_instr_retired = 1'b1;
        end
        S_BRANCH: begin
          bus.o_alu_src_a     = 1'b1;
          bus.o_alu_op_code   = ALU_SUB;
          bus.o_pc_write_cond = 1'b1;
          bus.o_pc_src        = 2'b01;
          bus.o_instr_retired = 1'b1;
        end
        S_JUMP: begin
          bus.o_pc_write      = 1'b1;
          bus.o_pc_src        = 2'b10;
          bus.o_instr_retired = 1'b1;
        end
        S_ADDI_EXEC: begin
          bus.o_alu_src_a = 1'b1;
          bus.o_alu_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          bus.o_w_en          = 1'b1;
          bus.o_instr_retired = 1'b1;
        end
        S_ILLEGAL: begin
          bus.o_illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MIPS_FSM_INSTR_COUNT_EN
  logic [CNT_W-1:0] instr_count;

  // Retired-instruction counter, wraps naturally at CNT_W bits
  always_ff @(posedge i_clk) begin
    if (i_reset)                  instr_count <= {CNT_W{1'b0}};
    else if (bus.o_instr_retired) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.o_instr_count = instr_count;
`else
  assign bus.o_instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_multicycle_control_fsm.sv
// Bench for mips_multicycle_control_fsm: an instruction-level model
// (per-opcode state route plus per-state output table) is checked every
// cycle, alongside hand-computed literal expectations per scenario.
module tb_mips_multicycle_control_fsm;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       w_en;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retired;
    logic       illegal;
  } outs_t;

  typedef int route_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          m_pos = 0;
  int unsigned m_cnt = 0;

  logic [3:0]       cap_st;
  outs_t            cap_v;
  logic [CNT_W-1:0] cap_cnt;

  logic [5:0] opq[$];
  logic       rdq[$];
  int         eq[$];
  outs_t      sv_q[$];

  // State sequence an instruction walks through, by opcode
  function automatic route_t route_of(input logic [5:0] op);
    route_t r;
    case (op)
      6'h23:   r = {0, 1, 2, 3, 4};
      6'h2B:   r = {0, 1, 2, 5};
      6'h00:   r = {0, 1, 6, 7};
      6'h04:   r = {0, 1, 8};
      6'h02:   r = {0, 1, 9};
      6'h08:   r = {0, 1, 10, 11};
      default: r = {0, 1, 12};
    endcase
    return r;
  endfunction

  // Required outputs for a state, from the control table
  function automatic outs_t exp_outs(input int st, input logic rdy, input logic r);
    outs_t o;
    o = '0;
    if (r) return o;
    case (st)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin o.alu_src_b = 2'b11; end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.mem_to_reg = 1; o.w_en = 1; o.retired = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; o.retired = rdy; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_dst = 1; o.w_en = 1; o.retired = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01; o.retired = 1; end
      9:  begin o.pc_write = 1; o.pc_src = 2'b10; o.retired = 1; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      11: begin o.w_en = 1; o.retired = 1; end
      12: begin o.illegal = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_n, got, exp);
    end
  endtask

  // One clock: apply inputs, sample mid-cycle, check against the model, advance
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
    route_t rt;
    int     st;
    outs_t  ev;
    rst             = r;
    bus.i_op_code   = op;
    bus.i_mem_ready = rdy;
    #4;
    cap_st  = bus.o_state;
    cap_cnt = bus.o_instr_count;
    cap_v   = {bus.o_pc_write, bus.o_pc_write_cond, bus.o_pc_src, bus.o_ir_write,
               bus.o_i_or_d, bus.o_mem_read, bus.o_mem_write, bus.o_mem_to_reg,
               bus.o_reg_dst, bus.o_w_en, bus.o_alu_src_a, bus.o_alu_src_b,
               bus.o_alu_op_code, bus.o_instr_retired, bus.o_illegal};
    rt = route_of(op);
    st = rt[m_pos];
    ev = exp_outs(st, rdy, r);
    check("model_state", {28'd0, cap_st}, st);
    check("model_outputs", {14'd0, cap_v}, {14'd0, ev});
`ifdef MIPS_FSM_INSTR_COUNT_EN
    check("model_count", {28'd0, cap_cnt}, m_cnt);
`else
    check("model_count", {28'd0, cap_cnt}, 0);
`endif
    check("rd_wr_exclusive", {31'd0, cap_v.mem_read & cap_v.mem_write}, 0);
    if (r) begin
      m_pos = 0;
      m_cnt = 0;
    end else begin
      if (ev.retired) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if ((st == 0 || st == 3 || st == 5) && !rdy) m_pos = m_pos;
      else if (st == 12)                           m_pos = m_pos;
      else if (m_pos == rt.size() - 1)             m_pos = 0;
      else                                         m_pos = m_pos + 1;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Run the queued op/ready/expected-state vectors, keeping captured outputs
  task automatic run_list(input string name);
    sv_q.delete();
    foreach (eq[i]) begin
      cyc(1'b0, opq[i], rdq[i]);
      check(name, {28'd0, cap_st}, eq[i]);
      sv_q.push_back(cap_v);
    end
  endtask

  task automatic clear_lists();
    opq.delete();
    rdq.delete();
    eq.delete();
  endtask

  initial begin
    int n;
    int m;
    int k;
    bus.i_op_code   = 6'h23;
    bus.i_mem_ready = 1'b1;
    rst             = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: FETCH, every strobe low
    cyc(1'b1, 6'h23, 1'b1);
    check("reset_state", {28'd0, cap_st}, 0);
    check("reset_strobes", {14'd0, cap_v}, 0);

    // lw with ready always high
    clear_lists();
    opq = {6'h23, 6'h23, 6'h23, 6'h23, 6'h23};
    rdq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    eq  = {0, 1, 2, 3, 4};
    run_list("lw_state");
    n = 0; m = 0;
    foreach (sv_q[i]) begin
      n += int'(sv_q[i].w_en);
      m += int'(sv_q[i].retired);
    end
    check("lw_wen_cycles", n, 1);
    check("lw_retired_pulses", m, 1);
    check("lw_wb_strobes", {31'd0, sv_q[4].mem_to_reg & sv_q[4].w_en}, 1);

    // R-type, beq, addi back to back
    clear_lists();
    opq = {6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h04, 6'h04, 6'h08, 6'h08, 6'h08, 6'h08};
    rdq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    eq  = {0, 1, 6, 7, 0, 1, 8, 0, 1, 10, 11};
    run_list("rbeq_state");
    check("rexec_alu_op", {30'd0, sv_q[2].alu_op}, 2);
    check("rwb_reg_dst", {31'd0, sv_q[3].reg_dst}, 1);
    check("beq_alu_op", {30'd0, sv_q[6].alu_op}, 1);
    check("beq_pc_write_cond", {31'd0, sv_q[6].pc_write_cond}, 1);
    check("beq_pc_src", {30'd0, sv_q[6].pc_src}, 1);

    // sw with ready low 3 cycles in FETCH and 2 in MEM_WR
    clear_lists();
    opq = {6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    rdq = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    eq  = {0, 0, 0, 0, 1, 2, 5, 5, 5};
    run_list("sw_state");
    n = 0; m = 0; k = 0;
    foreach (sv_q[i]) begin
      n += int'(sv_q[i].ir_write);
      m += int'(sv_q[i].mem_write);
      k += int'(sv_q[i].retired);
    end
    check("sw_ir_write_cycles", n, 1);
    check("sw_ir_write_on_ready", {31'd0, sv_q[3].ir_write & sv_q[3].pc_write}, 1);
    check("sw_mem_write_cycles", m, 3);
    check("sw_retired_pulses", k, 1);
    check("sw_retire_last", {31'd0, sv_q[8].retired}, 1);

    // Unsupported opcode traps and holds
    clear_lists();
    for (int i = 0; i < 13; i++) begin
      opq.push_back(6'h3F);
      rdq.push_back(1'b1);
      eq.push_back(i < 2 ? i : 12);
    end
    run_list("illegal_state");
    check("illegal_only_flag", {14'd0, sv_q[12]}, 1);
    check("illegal_held_state", {28'd0, cap_st}, 12);
    cyc(1'b1, 6'h3F, 1'b1);
    check("illegal_cleared_in_reset", {14'd0, cap_v}, 0);
    cyc(1'b0, 6'h23, 1'b1);
    check("illegal_exit_state", {28'd0, cap_st}, 0);

    // Reset during MEM_RD abandons the load without a write
    cyc(1'b0, 6'h23, 1'b1);
    cyc(1'b0, 6'h23, 1'b0);
    check("memrd_wait_state", {28'd0, cap_st}, 2);
    cyc(1'b0, 6'h23, 1'b0);
    check("memrd_state", {28'd0, cap_st}, 3);
    cyc(1'b1, 6'h23, 1'b1);
    check("memrd_reset_state", {28'd0, cap_st}, 3);
    check("memrd_reset_wen", {31'd0, cap_v.w_en}, 0);
    check("memrd_reset_read", {31'd0, cap_v.mem_read}, 0);
    cyc(1'b0, 6'h23, 1'b1);
    check("memrd_after_reset", {28'd0, cap_st}, 0);

    // 17 jumps from a cleared counter
    cyc(1'b1, 6'h02, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 6'h02, 1'b1);
      if (i == 0) check("j_state0", {28'd0, cap_st}, 0);
      cyc(1'b0, 6'h02, 1'b1);
      if (i == 0) check("j_state1", {28'd0, cap_st}, 1);
      cyc(1'b0, 6'h02, 1'b1);
      if (i == 0) check("j_state2", {28'd0, cap_st}, 9);
    end
    cyc(1'b0, 6'h02, 1'b1);
`ifdef MIPS_FSM_INSTR_COUNT_EN
    check("count_after_17_jumps", {28'd0, cap_cnt}, 1);
`else
    check("count_after_17_jumps", {28'd0, cap_cnt}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
